// File: rtl/regu_mp_pkg.sv
// Shared constants for the regu_mp multi-port register file.
// Holds the reset level, the clear-engine state encoding and the default sizes.
package regu_mp_pkg;

  // rst is active-high
  localparam logic RST_ACTIVE = 1'b1;

  // Default geometry
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  // All-zero word at the default width
  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

  // Clear-engine states: INIT sweeps storage, READY is the operational state
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/regu_mp_scoreboard.sv
// Busy-bit scoreboard for regu_mp: one bit per register.
// A write clears the bit of its address, an allocation sets it, and set wins
// over clear so a freshly issued producer is never lost.
module regu_mp_scoreboard
  import regu_mp_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic                 alloc_en_i,
  input  logic [AW-1:0]        alloc_addr_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clears from every write port first, then the allocation set
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_i[j]) busy_d[wr_addr_i[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en_i && !(ZERO_REG != 0 && alloc_addr_i == '0)) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
  end

  // Busy state register, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) busy_q <= '0;
    else                   busy_q <= busy_d;
  end

  // Per-port lookup of the registered (pre-edge) busy bit
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy_o[k] = busy_q[rd_addr_i[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regu_mp.sv
// regu_mp: parametrised multi-port integer register file with a post-reset
// clear sweep and a busy scoreboard. Optional same-cycle write-to-read
// forwarding is compiled in with the macro REGU_MP_BYPASS_EN.
module regu_mp
  import regu_mp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*AW-1:0]     wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  output logic                     init_done_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              ready;
  logic [NUM_WR-1:0] wr_ok;
  logic [NUM_RD-1:0] sb_busy;
  logic [DATA_W-1:0] mem [DEPTH];

  assign ready = (state_q == ST_READY);

  // Clear-engine FSM: sweep one register per cycle, then park in READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_o <= 1'b0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == LAST_ADDR) begin
        state_q     <= ST_READY;
        init_done_o <= 1'b1;
      end
    end
  end

  // Effective write enables: only in READY, and never to the hardwired zero register
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = ready && wr_en_i[j] &&
                 !(ZERO_REG != 0 && wr_addr_i[j*AW +: AW] == '0);
    end
  end

  // Storage: sweep clear during INIT, port writes in READY (later port overrides earlier)
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the INIT sweep clears it, which keeps it mappable to plain RAM.
    if (!ready) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) mem[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  regu_mp_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_ok),
    .wr_addr_i    (wr_addr_i),
    .alloc_en_i   (alloc_en_i && ready),
    .alloc_addr_i (alloc_addr_i),
    .rd_addr_i    (rd_addr_i),
    .rd_busy_o    (sb_busy)
  );

  // Read ports: zero outside READY, optional forwarding from same-cycle writes
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    if (ready) begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (!(ZERO_REG != 0 && rd_addr_i[k*AW +: AW] == '0)) begin
          rd_data_o[k*DATA_W +: DATA_W] = mem[rd_addr_i[k*AW +: AW]];
        end
        rd_busy_o[k] = sb_busy[k];
`ifdef REGU_MP_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_ok[j] && wr_addr_i[j*AW +: AW] == rd_addr_i[k*AW +: AW]) begin
            rd_data_o[k*DATA_W +: DATA_W] = wr_data_i[j*DATA_W +: DATA_W];
            rd_busy_o[k]                  = 1'b0;
          end
        end
`else
        // Without forwarding a same-cycle write stays invisible until after the edge
`endif
      end
    end
  end

endmodule

// File: tb/tb_regu_mp.sv
// Directed self-checking bench for regu_mp (DEPTH=32, DATA_W=32, two read and
// two write ports, ZERO_REG=1). Bypass expectations follow REGU_MP_BYPASS_EN.
module tb_regu_mp;

  localparam int DW  = 32;
  localparam int DEP = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic              init_done;

  int total = 0;
  int bad   = 0;

  regu_mp #(
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .init_done_o  (init_done)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    alloc_en = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[j]            = 1'b1;
    wr_addr[j*AW +: AW] = a;
    wr_data[j*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rdat(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // Counts 32 edges after rst release; init_done must be 0 until the 32nd, then 1
  task automatic wait_sweep(input string tag);
    logic exp;
    for (int i = 1; i <= DEP; i++) begin
      tick();
      if (i == DEP) idle();
      exp = (i == DEP);
      if (i == DEP - 1 || i == DEP) begin
        total++;
        if (init_done !== exp) begin
          bad++;
          $display("FAIL %s init_done edge %0d got=%b exp=%b", tag, i, init_done, exp);
        end
      end else if (init_done !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL %s init_done early at edge %0d got=%b exp=0", tag, i, init_done);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    rd_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_addr = '0;
    idle();
    set_rd(0, 5'd4);
    set_rd(1, 5'd17);
    tick();
    tick();
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL reset init_done got=%b exp=0", init_done);
    end
    total++;
    if (rd_data !== '0) begin
      bad++; $display("FAIL reset rd_data got=%h exp=0", rd_data);
    end
    total++;
    if (rd_busy !== '0) begin
      bad++; $display("FAIL reset rd_busy got=%b exp=0", rd_busy);
    end
    rst = 1'b0;
    wait_sweep("reset_sweep");
    for (int a = 0; a < DEP; a += 2) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      #1;
      total++;
      if (rd_data !== '0 || rd_busy !== '0) begin
        bad++; $display("FAIL reset clear x%0d/x%0d got=%h busy=%b exp=0", a, a + 1, rd_data, rd_busy);
      end
    end
  endtask

  task automatic test_basic();
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5);
    set_rd(1, 5'd0);
    #1;
    total++;
`ifdef REGU_MP_BYPASS_EN
    if (rdat(0) !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic same-cycle x5 got=%h exp=deadbeef", rdat(0));
    end
`else
    if (rdat(0) !== 32'h0) begin
      bad++; $display("FAIL basic same-cycle x5 got=%h exp=0", rdat(0));
    end
`endif
    tick();
    idle();
    set_rd(1, 5'd5);
    #1;
    total++;
    if (rdat(0) !== 32'hDEADBEEF || rdat(1) !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic x5 got=%h/%h exp=deadbeef", rdat(0), rdat(1));
    end
    set_wr(1, 5'd0, 32'h1234);
    set_rd(0, 5'd0);
    #1;
    total++;
    if (rdat(0) !== 32'h0) begin
      bad++; $display("FAIL basic x0 same-cycle got=%h exp=0", rdat(0));
    end
    tick();
    idle();
    #1;
    total++;
    if (rdat(0) !== 32'h0) begin
      bad++; $display("FAIL basic x0 got=%h exp=0", rdat(0));
    end
  endtask

  task automatic test_conflict();
    set_wr(0, 5'd7, 32'h11);
    set_wr(1, 5'd7, 32'h22);
    tick();
    idle();
    set_rd(0, 5'd7);
    #1;
    total++;
    if (rdat(0) !== 32'h22) begin
      bad++; $display("FAIL conflict x7 got=%h exp=22", rdat(0));
    end
    set_wr(0, 5'd10, 32'hA0A0);
    set_wr(1, 5'd11, 32'hB1B1);
    tick();
    idle();
    set_rd(0, 5'd10);
    set_rd(1, 5'd11);
    #1;
    total++;
    if (rdat(0) !== 32'hA0A0 || rdat(1) !== 32'hB1B1) begin
      bad++; $display("FAIL dual write got=%h/%h exp=a0a0/b1b1", rdat(0), rdat(1));
    end
  endtask

  task automatic test_scoreboard();
    set_rd(0, 5'd3);
    set_rd(1, 5'd0);
    alloc_en   = 1'b1;
    alloc_addr = 5'd3;
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL sb pre-edge x3 busy got=%b exp=0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1) begin
      bad++; $display("FAIL sb alloc x3 busy got=%b exp=1", rd_busy[0]);
    end
    set_wr(0, 5'd3, 32'h33);
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL sb write-clear x3 busy got=%b exp=0", rd_busy[0]);
    end
    set_wr(0, 5'd3, 32'h34);
    alloc_en   = 1'b1;
    alloc_addr = 5'd3;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || rdat(0) !== 32'h34) begin
      bad++; $display("FAIL sb alloc+write x3 busy=%b data=%h exp busy=1 data=34", rd_busy[0], rdat(0));
    end
    set_wr(1, 5'd3, 32'h35);
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0) begin
      bad++; $display("FAIL sb port1 clear x3 busy got=%b exp=0", rd_busy[0]);
    end
    alloc_en   = 1'b1;
    alloc_addr = 5'd0;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[1] !== 1'b0) begin
      bad++; $display("FAIL sb alloc x0 busy got=%b exp=0", rd_busy[1]);
    end
  endtask

  task automatic test_bypass();
    set_wr(0, 5'd9, 32'h1111);
    alloc_en   = 1'b1;
    alloc_addr = 5'd9;
    tick();
    idle();
    set_rd(0, 5'd9);
    set_rd(1, 5'd9);
    set_wr(1, 5'd9, 32'hCAFE);
    #1;
    total++;
`ifdef REGU_MP_BYPASS_EN
    if (rdat(0) !== 32'hCAFE || rd_busy !== 2'b00) begin
      bad++; $display("FAIL bypass x9 got=%h busy=%b exp=cafe busy=00", rdat(0), rd_busy);
    end
`else
    if (rdat(0) !== 32'h1111 || rd_busy !== 2'b11) begin
      bad++; $display("FAIL bypass x9 got=%h busy=%b exp=1111 busy=11", rdat(0), rd_busy);
    end
`endif
    tick();
    idle();
    #1;
    total++;
    if (rdat(1) !== 32'hCAFE || rd_busy !== 2'b00) begin
      bad++; $display("FAIL bypass after x9 got=%h busy=%b exp=cafe busy=00", rdat(1), rd_busy);
    end
  endtask

  task automatic test_midreset();
    alloc_en   = 1'b1;
    alloc_addr = 5'd6;
    tick();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    set_wr(0, 5'd5, 32'hBAD0);
    set_wr(1, 5'd6, 32'hBAD1);
    alloc_en   = 1'b1;
    alloc_addr = 5'd6;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (init_done !== 1'b0 || rd_data !== '0 || rd_busy !== '0) begin
        bad++; $display("FAIL midreset INIT edge %0d done=%b data=%h busy=%b exp all 0", i, init_done, rd_data, rd_busy);
      end
    end
    rst = 1'b1;
    tick();
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL midreset in rst init_done got=%b exp=0", init_done);
    end
    rst = 1'b0;
    wait_sweep("midreset_sweep");
    #1;
    total++;
    if (rdat(0) !== 32'h0 || rdat(1) !== 32'h0 || rd_busy !== 2'b00) begin
      bad++; $display("FAIL midreset x5/x6 got=%h/%h busy=%b exp=0/0 busy=00", rdat(0), rdat(1), rd_busy);
    end
    set_rd(0, 5'd9);
    set_rd(1, 5'd7);
    #1;
    total++;
    if (rd_data !== '0) begin
      bad++; $display("FAIL midreset x9/x7 got=%h exp=0", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regu_mp.md
Name: regu_mp

Overview:
- Parametrised multi-port integer register file; next generation of the single-issue regu.
- Sits between id (read ports, destination allocation) and ex/wb (write ports).
- Adds configurable depth, width and read/write port counts.
- Adds a sequential post-reset clear engine and a per-register busy scoreboard for hazard detection.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >=2)
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- rd_addr_i  in  NUM_RD*AW  read addresses; port k at [k*AW +: AW]
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational
- rd_busy_o  out  NUM_RD  scoreboard busy bit of each addressed register
- wr_en_i  in  NUM_WR  write enables
- wr_addr_i  in  NUM_WR*AW  write addresses
- wr_data_i  in  NUM_WR*DATA_W  write data
- alloc_en_i  in  1  mark a destination register busy (issue)
- alloc_addr_i  in  AW  register to mark busy
- init_done_o  out  1  1 once the clear sweep has finished

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- While rst=1:
  - FSM forced to INIT; sweep counter = 0; all busy bits = 0.
  - init_done_o = 0; rd_data_o = 0; rd_busy_o = 0.
- FSM states are INIT and READY.
- INIT:
  - One register cleared per cycle at the counter address; counter increments by 1.
  - When the counter = DEPTH-1, that register is cleared and the FSM moves to READY.
  - init_done_o goes to 1 exactly DEPTH cycles after rst deasserts.
  - During INIT, wr_en_i and alloc_en_i are ignored, rd_data_o = 0 and rd_busy_o = 0.
- READY:
  - Terminal state; left only by rst.
  - rst asserted mid-operation restarts the full sweep; storage contents are not preserved.
- Reads:
  - Combinational; rd_data_o[k] = storage[rd_addr_i[k]].
  - With ZERO_REG=1, address 0 always reads 0.
- Writes:
  - Storage updated on the rising edge when wr_en_i[j]=1.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - If several ports target the same address in one cycle, the highest-index port wins.
- Scoreboard (one bit per register):
  - A write on any port clears the busy bit of its address.
  - alloc_en_i sets the busy bit of alloc_addr_i.
  - Same-cycle alloc and write to the same address: set wins, so the bit stays busy for the new producer.
  - With ZERO_REG=1, register 0 is never set.
  - rd_busy_o[k] = busy[rd_addr_i[k]], taken from registered state (pre-edge value).
- Latency: a write is visible on rd_data_o the cycle after the edge, unless the optional bypass below is compiled in.
- Out-of-range addresses cannot occur because DEPTH is a power of two.

Optional Feature:
- Macro: REGU_MP_BYPASS_EN.
- Defined:
  - Same-cycle forwarding: if wr_en_i[j] is set and wr_addr_i[j] == rd_addr_i[k] (nonzero when ZERO_REG=1), rd_data_o[k] = wr_data_i[j], highest j wins.
  - rd_busy_o[k] is forced to 0 for that port in that cycle.
  - Active only in READY.
- Undefined: no forwarding; the read returns the pre-write value for that cycle and rd_busy_o shows the registered bit.

Decomposition:
- Constants go in define.v:
  - reset-active level for rst
  - INIT/READY state encodings
  - default DATA_W and DEPTH
  - zero word
- One natural sub-module, regu_mp_scoreboard: busy-bit array with set/clear priority and per-port busy lookup.
- Storage, write arbitration, bypass and init FSM stay in regu_mp.

Test Plan:
- Reset clear: preload by writes, pulse rst for 2 cycles, release -> init_done_o=0 for 32 cycles, rises on cycle 32; all reads return 0 after that.
- Basic write/read (defaults): write x5=0xDEADBEEF; next cycle rd_addr port0=5 -> 0xDEADBEEF. Write x0=0x1234 -> x0 reads 0.
- Port conflict (NUM_WR=2): both ports write x7 with 0x11 and 0x22 in one cycle -> x7 reads 0x22.
- Scoreboard: alloc x3 -> rd_busy_o=1 next cycle; write x3 -> busy 0 next cycle. Alloc and write x3 in the same cycle -> busy stays 1.
- Bypass: write x9=0xCAFE while reading x9 in the same cycle -> with REGU_MP_BYPASS_EN, 0xCAFE and busy 0; without it, the old value.
- Mid-sweep reset: assert rst at sweep cycle 10 -> init_done_o stays 0 and the sweep restarts from 0; writes during INIT have no effect.
